// File: rtl/pwm_gen_core.sv
// -----------------------------------------------------------------------------
// pwm_gen_core
// Single-channel PWM generator. The active period/duty registers take their
// values from a shadow set only at a period boundary, or at once while the
// generator is disabled, so the waveform never glitches mid-period.
//
// Ports
//   pclk                system clock, rising edge
//   rst                 asynchronous reset, active high
//   pwm_en              level, run the generator
//   up / down           rising edge: shadow duty +/- STEP (saturating)
//   initial_cycle       period value staged by initial_update
//   initial_duty_cycle  duty value staged by initial_update
//   initial_update      rising edge: stage initial_cycle and initial_duty_cycle
//   duty_cycle_update   rising edge: stage duty_cycle
//   duty_cycle          duty value staged by duty_cycle_update
//   pwm_o               registered PWM output
//   period_end          high in the last clock of each period while enabled
//   cur_cycle           active period register (period = cur_cycle + 1 clocks)
//   cur_duty            active duty register (high time in clocks)
//   update_pending      shadow set staged but not yet applied
// -----------------------------------------------------------------------------
module pwm_gen_core #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RST_CYCLE = 999,
    parameter int unsigned RST_DUTY  = 500
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             pwm_en,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] initial_cycle,
    input  logic [WIDTH-1:0] initial_duty_cycle,
    input  logic             initial_update,
    input  logic             duty_cycle_update,
    input  logic [WIDTH-1:0] duty_cycle,
    output logic             pwm_o,
    output logic             period_end,
    output logic [WIDTH-1:0] cur_cycle,
    output logic [WIDTH-1:0] cur_duty,
    output logic             update_pending
);

    localparam logic [WIDTH-1:0] RstCycle = WIDTH'(RST_CYCLE);
    localparam logic [WIDTH-1:0] RstDuty  = WIDTH'(RST_DUTY);
    localparam logic [WIDTH:0]   StepW    = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   MaxW     = {1'b0, {WIDTH{1'b1}}};

    // Strobe vector bit order: 0 up, 1 down, 2 duty_cycle_update, 3 initial_update
    logic [3:0]       strb_cur_q, strb_cur_d;
    logic [3:0]       strb_prev_q, strb_prev_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cycle_reg_q, cycle_reg_d;
    logic [WIDTH-1:0] duty_reg_q, duty_reg_d;
    logic [WIDTH-1:0] sh_cycle_q, sh_cycle_d;
    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;

    logic [3:0]       strb_rise;
    logic             at_wrap;
    logic             apply;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_lim;
    logic [WIDTH:0]   up_min;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] down_val;

    always_comb begin
        strb_rise = strb_cur_q & ~strb_prev_q;
        at_wrap   = (cnt_q == cycle_reg_q);
        apply     = pending_q & (~pwm_en | at_wrap);

        // Steps accumulate on the staged duty if one is waiting.
        base   = pending_q ? sh_duty_q : duty_reg_q;

        // Upper bound is one past the period (100% duty), computed one bit wider
        // so neither the sum nor the limit can wrap.
        up_sum = {1'b0, base} + StepW;
        up_lim = {1'b0, sh_cycle_q} + (WIDTH + 1)'(1);
        up_min = (up_sum > up_lim) ? up_lim : up_sum;
        up_val = (up_min > MaxW) ? {WIDTH{1'b1}} : up_min[WIDTH-1:0];

        down_val = ({1'b0, base} >= StepW) ? (base - StepW[WIDTH-1:0]) : '0;
    end

    always_comb begin
        strb_cur_d  = {initial_update, duty_cycle_update, down, up};
        strb_prev_d = strb_cur_q;
        cycle_reg_d = cycle_reg_q;
        duty_reg_d  = duty_reg_q;
        sh_cycle_d  = sh_cycle_q;
        sh_duty_d   = sh_duty_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;

        if (apply) begin
            cycle_reg_d = sh_cycle_q;
            duty_reg_d  = sh_duty_q;
            pending_d   = 1'b0;
        end

        // Staging after apply: an edge in the apply cycle re-stages and keeps
        // pending set, while the apply itself uses the old shadow values.
        if (strb_rise[3]) begin
            sh_cycle_d = initial_cycle;
            sh_duty_d  = initial_duty_cycle;
            pending_d  = 1'b1;
        end else if (strb_rise[2]) begin
            sh_duty_d = duty_cycle;
            pending_d = 1'b1;
        end else if (strb_rise[0] ^ strb_rise[1]) begin
            sh_duty_d = strb_rise[0] ? up_val : down_val;
            pending_d = 1'b1;
        end

        if (!pwm_en || apply || at_wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        pwm_d = pwm_en & (cnt_q < duty_reg_q);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            strb_cur_q  <= '0;
            strb_prev_q <= '0;
            cnt_q       <= '0;
            cycle_reg_q <= RstCycle;
            duty_reg_q  <= RstDuty;
            sh_cycle_q  <= RstCycle;
            sh_duty_q   <= RstDuty;
            pending_q   <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            strb_cur_q  <= strb_cur_d;
            strb_prev_q <= strb_prev_d;
            cnt_q       <= cnt_d;
            cycle_reg_q <= cycle_reg_d;
            duty_reg_q  <= duty_reg_d;
            sh_cycle_q  <= sh_cycle_d;
            sh_duty_q   <= sh_duty_d;
            pending_q   <= pending_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_o          = pwm_q;
    assign period_end     = pwm_en & at_wrap;
    assign cur_cycle      = cycle_reg_q;
    assign cur_duty       = duty_reg_q;
    assign update_pending = pending_q;

endmodule
